// File: rtl/lsu_mem_initiator_if.sv
// Bundle between the LSU, its requester and data_mem.
// master = LSU view; slave = requester/memory view.
interface lsu_mem_initiator_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid,
    input  req_store,
    input  req_funct3,
    input  req_addr,
    input  req_wdata,
    input  mem_rdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output req_valid,
    output req_store,
    output req_funct3,
    output req_addr,
    output req_wdata,
    output mem_rdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// RV32 load/store initiator for a word-wide data_mem; sub-word stores use RMW.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses error instead of masking.
module lsu_mem_initiator #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] MEM_TOP = ADDR_W'('h8000)
) (
  input  logic                clk,
  input  logic                rst_n,
  lsu_mem_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RSP
  } state_t;

  localparam logic [ADDR_W:0] TOP_X = {1'b0, MEM_TOP};
  localparam logic [ADDR_W:0] THREE = (ADDR_W+1)'(3);

  state_t            st_q, st_d;
  logic              store_q, store_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lo_q, lo_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   span;
  logic              oob;
  logic              f3_bad;
  logic              mis;
  logic              req_err;
  logic              is_sw;

  function automatic logic [31:0] ld_ext(
    input logic [31:0] w,
    input logic [2:0]  f3,
    input logic [1:0]  a
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    r = w;
    unique case (1'b1)
      (f3[1:0] == 2'b00): r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      (f3[1:0] == 2'b01): r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default:            r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] st_merge(
    input logic [31:0] w,
    input logic [15:0] d,
    input logic [2:0]  f3,
    input logic [1:0]  a
  );
    logic [31:0] r;
    r = w;
    unique case (1'b1)
      (f3[1:0] == 2'b00): r[{a, 3'b000} +: 8] = d[7:0];
      (f3[1:0] == 2'b01): r[{a[1], 4'b0000} +: 16] = d;
      default:            r = w;
    endcase
    return r;
  endfunction

  assign waddr = {bus.req_addr[ADDR_W-1:2], 2'b00};
  assign span  = {1'b0, waddr} + THREE;
  assign oob   = span > TOP_X;
  assign is_sw = bus.req_store & (bus.req_funct3 == 3'b010);

  always_comb begin
    f3_bad = 1'b1;
    unique case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
      3'b100, 3'b101:         f3_bad = bus.req_store;
      default:                f3_bad = 1'b1;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    mis = 1'b0;
    unique case (bus.req_funct3[1:0])
      2'b01:   mis = bus.req_addr[0];
      2'b10:   mis = |bus.req_addr[1:0];
      default: mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  assign req_err = f3_bad | oob | mis;

  always_comb begin
    st_d     = st_q;
    store_d  = store_q;
    f3_d     = f3_q;
    lo_d     = lo_q;
    wdata_d  = wdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (st_q)
      IDLE: begin
        if (bus.req_valid) begin
          store_d = bus.req_store;
          f3_d    = bus.req_funct3;
          lo_d    = bus.req_addr[1:0];
          wdata_d = bus.req_wdata[15:0];
          if (req_err) begin
            st_d    = RSP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            maddr_d = waddr;
            if (is_sw) begin
              st_d     = WR;
              mwdata_d = bus.req_wdata;
            end else begin
              st_d = RD;
            end
          end
        end
      end
      RD: begin
        if (store_q) begin
          st_d     = WR;
          mwdata_d = st_merge(bus.mem_rdata,
                              wdata_q, f3_q, lo_q);
        end else begin
          st_d    = RSP;
          err_d   = 1'b0;
          rdata_d = ld_ext(bus.mem_rdata, f3_q, lo_q);
        end
      end
      WR: begin
        st_d    = RSP;
        err_d   = 1'b0;
        rdata_d = 32'd0;
      end
      RSP:     st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q     <= IDLE;
      store_q  <= 1'b0;
      f3_q     <= 3'd0;
      lo_q     <= 2'd0;
      wdata_q  <= 16'd0;
      maddr_q  <= '0;
      mwdata_q <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      store_q  <= store_d;
      f3_q     <= f3_d;
      lo_q     <= lo_d;
      wdata_q  <= wdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // write strobe gated by reset so an aborted WR never lands
  assign bus.mem_we    = (st_q == WR) & rst_n;
  assign bus.req_ready = (st_q == IDLE);
  assign bus.rsp_valid = (st_q == RSP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a word-wide memory model.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_lsu_mem_initiator;

  logic clk;
  logic rst_n;

  lsu_mem_initiator_if #(.ADDR_W(32)) bus ();

  lsu_mem_initiator #(
    .ADDR_W (32),
    .MEM_TOP(32'h8000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] mem [0:8191];
  logic        poke_en;
  logic [12:0] poke_idx;
  logic [31:0] poke_val;

  int n_vec;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[14:2]];

  always @(posedge clk) begin
    if (poke_en)
      mem[poke_idx] <= poke_val;
    else if (bus.mem_we)
      mem[bus.mem_addr[14:2]] <= bus.mem_wdata;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic poke(
    input logic [12:0] idx,
    input logic [31:0] val
  );
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic run(
    input  logic        st,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        er,
    output int          lat,
    output int          wes,
    output logic [31:0] wa,
    output logic [31:0] ww
  );
    rd  = 32'hdead_beef;
    er  = 1'bx;
    lat = -1;
    wes = 0;
    wa  = 32'd0;
    ww  = 32'd0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        wes++;
        wa = bus.mem_addr;
        ww = bus.mem_wdata;
      end
      if (bus.rsp_valid) begin
        lat = c;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
        break;
      end
    end
  endtask

  logic [31:0] rd, wa, ww;
  logic        er;
  int          lat, wes;

  initial begin
    n_vec          = 0;
    n_bad          = 0;
    rst_n          = 1'b0;
    poke_en        = 1'b0;
    poke_idx       = '0;
    poke_val       = '0;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rvalid", 32'(bus.rsp_valid), 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_maddr", bus.mem_addr, 32'd0);
    check("rst_mwdata", bus.mem_wdata, 32'd0);
    rst_n = 1'b1;

    poke(13'h040, 32'h1234_5678);
    run(0, 3'b010, 32'h100, 0, rd, er, lat, wes, wa, ww);
    check("lw_data", rd, 32'h1234_5678);
    check("lw_err", 32'(er), 32'd0);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_we", 32'(wes), 32'd0);
    @(negedge clk);
    check("hold_valid", 32'(bus.rsp_valid), 32'd0);
    check("hold_rdata", bus.rsp_rdata, 32'h1234_5678);

    run(0, 3'b000, 32'h103, 0, rd, er, lat, wes, wa, ww);
    check("lb_103", rd, 32'h0000_0012);
    poke(13'h040, 32'h1234_9678);
    run(0, 3'b000, 32'h101, 0, rd, er, lat, wes, wa, ww);
    check("lb_101", rd, 32'hFFFF_FF96);
    run(0, 3'b100, 32'h101, 0, rd, er, lat, wes, wa, ww);
    check("lbu_101", rd, 32'h0000_0096);

    poke(13'h040, 32'h1234_5678);
    run(1, 3'b000, 32'h102, 32'hAB, rd, er, lat, wes, wa, ww);
    check("sb_we", 32'(wes), 32'd1);
    check("sb_maddr", wa, 32'h100);
    check("sb_wdata", ww, 32'h12AB_5678);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_rdata", rd, 32'd0);
    check("sb_mem", mem[13'h040], 32'h12AB_5678);

    poke(13'h040, 32'h1234_5678);
    run(1, 3'b001, 32'h102, 32'h5555_CDEF,
        rd, er, lat, wes, wa, ww);
    check("sh_err", 32'(er), 32'd0);
    check("sh_wdata", ww, 32'hCDEF_5678);
    check("sh_lat", 32'(lat), 32'd3);
    run(0, 3'b001, 32'h102, 0, rd, er, lat, wes, wa, ww);
    check("lh_102", rd, 32'hFFFF_CDEF);
    run(0, 3'b101, 32'h102, 0, rd, er, lat, wes, wa, ww);
    check("lhu_102", rd, 32'h0000_CDEF);

    run(0, 3'b010, 32'h101, 0, rd, er, lat, wes, wa, ww);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw101_err", 32'(er), 32'd1);
    check("lw101_data", rd, 32'd0);
    check("lw101_lat", 32'(lat), 32'd1);
`else
    check("lw101_err", 32'(er), 32'd0);
    check("lw101_data", rd, 32'hCDEF_5678);
    check("lw101_lat", 32'(lat), 32'd2);
`endif
    check("lw101_we", 32'(wes), 32'd0);

    run(0, 3'b010, 32'h8000, 0, rd, er, lat, wes, wa, ww);
    check("top_err", 32'(er), 32'd1);
    check("top_lat", 32'(lat), 32'd1);
    check("top_data", rd, 32'd0);
    poke(13'h1FFF, 32'hA500_0000);
    run(0, 3'b000, 32'h7FFF, 0, rd, er, lat, wes, wa, ww);
    check("lb7fff_err", 32'(er), 32'd0);
    check("lb7fff_data", rd, 32'hFFFF_FFA5);
    run(0, 3'b010, 32'h7FFE, 0, rd, er, lat, wes, wa, ww);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw7ffe_err", 32'(er), 32'd1);
`else
    check("lw7ffe_err", 32'(er), 32'd0);
    check("lw7ffe_data", rd, 32'hA500_0000);
`endif

    run(0, 3'b011, 32'h100, 0, rd, er, lat, wes, wa, ww);
    check("f3_011_err", 32'(er), 32'd1);
    check("f3_011_lat", 32'(lat), 32'd1);
    run(1, 3'b100, 32'h100, 32'h77, rd, er, lat, wes, wa, ww);
    check("sbu_err", 32'(er), 32'd1);
    check("sbu_we", 32'(wes), 32'd0);
    check("sbu_mem", mem[13'h040], 32'hCDEF_5678);

    // abort an SB while its write strobe is up
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h100;
    bus.req_wdata  = 32'hEE;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_wr", 32'(bus.mem_we), 32'd1);
    rst_n = 1'b0;
    #1 check("abort_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    check("abort_rv", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_rv2", 32'(bus.rsp_valid), 32'd0);
    check("abort_mem", mem[13'h040], 32'hCDEF_5678);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
